// File: rtl/sop_vector_scanner.sv
`default_nettype none
// ============================================================================
// Module      : sop_vector_scanner
// Description : Drives all 16 ABCD vectors into a 4-input SOP block, samples
//               its output after a settle time, and reports the truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module sop_vector_scanner #(
   parameter int DWELL_CYCLES = 3,
   parameter int DWELL_W      = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        f_in_i,
   output logic        a_o,
   output logic        b_o,
   output logic        c_o,
   output logic        d_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] truth_o,
   output logic [4:0]  ones_cnt_o
);

   // A zero dwell would never reach its terminal count, so it behaves as one.
   localparam int                 c_dwell_eff  = (DWELL_CYCLES == 0) ? 1 : DWELL_CYCLES;
   localparam logic [DWELL_W-1:0] c_dwell_last = DWELL_W'(c_dwell_eff - 1);

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_drive  = 2'd1;
   localparam logic [1:0] c_st_sample = 2'd2;
   localparam logic [1:0] c_st_finish = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [3:0]         idx_q, idx_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [3:0]         vec_q, vec_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [15:0]        truth_q, truth_d;
   logic [4:0]         ones_q, ones_d;

   // State and registered-output storage
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= c_st_idle;
         idx_q   <= 4'd0;
         dwell_q <= '0;
         vec_q   <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         truth_q <= 16'd0;
         ones_q  <= 5'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dwell_q <= dwell_d;
         vec_q   <= vec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         truth_q <= truth_d;
         ones_q  <= ones_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_st_idle:   if (start_i) state_d = c_st_drive;
         c_st_drive:  if (dwell_q == c_dwell_last) state_d = c_st_sample;
         c_st_sample: state_d = (idx_q == 4'hF) ? c_st_finish : c_st_drive;
         c_st_finish: state_d = c_st_idle;
         default:     state_d = c_st_idle;
      endcase
   end

   // Next values of the datapath and registered outputs
   always_comb begin
      idx_d   = idx_q;
      dwell_d = dwell_q;
      vec_d   = vec_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      truth_d = truth_q;
      ones_d  = ones_q;
      case (state_q)
         c_st_idle: begin
            vec_d = 4'd0;
            if (start_i) begin
               idx_d   = 4'd0;
               dwell_d = '0;
               truth_d = 16'd0;
               ones_d  = 5'd0;
               busy_d  = 1'b1;
            end
         end
         c_st_drive: begin
            vec_d   = idx_q;
            dwell_d = dwell_q + 1'b1;
         end
         c_st_sample: begin
            truth_d[idx_q] = f_in_i;
            ones_d         = ones_q + {4'd0, f_in_i};
            if (idx_q == 4'hF) begin
               // BUSY drops as DONE rises so the two never overlap.
               done_d = 1'b1;
               busy_d = 1'b0;
               vec_d  = 4'd0;
            end else begin
               idx_d   = idx_q + 4'd1;
               dwell_d = '0;
               vec_d   = idx_q + 4'd1;
            end
         end
         c_st_finish: begin
            vec_d  = 4'd0;
            busy_d = 1'b0;
         end
         default: begin
            vec_d  = 4'd0;
            busy_d = 1'b0;
         end
      endcase
   end

   assign a_o        = vec_q[3];
   assign b_o        = vec_q[2];
   assign c_o        = vec_q[1];
   assign d_o        = vec_q[0];
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign truth_o    = truth_q;
   assign ones_cnt_o = ones_q;

endmodule
`default_nettype wire

// File: tb/tb_sop_vector_scanner.sv
`default_nettype none
// Bench for sop_vector_scanner: randomized SOP tables, scoreboard of expected
// scan results, and a per-cycle monitor of the vector/handshake timing.
module tb_sop_vector_scanner;

   localparam int DW   = 3;
   localparam int P    = DW + 1;
   localparam int SCAN = 16 * P;

   typedef struct packed {
      logic [15:0] truth;
      logic [4:0]  ones;
      logic [31:0] done_cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        f_in;
   logic        a, b, c, d;
   logic        busy, done;
   logic [15:0] truth;
   logic [4:0]  ones;

   logic [15:0] fn_tbl     = 16'd0;
   logic        glitch_en  = 1'b0;
   logic        glitch_rnd = 1'b0;
   logic        mon_en     = 1'b0;
   int          cyc        = 0;
   int          cur_base   = -1;
   int          checks     = 0;
   int          failures   = 0;
   logic [15:0] hold_truth = 16'd0;
   logic [4:0]  hold_ones  = 5'd0;
   exp_t        sb[$];

   sop_vector_scanner #(.DWELL_CYCLES(DW), .DWELL_W(8)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .f_in_i     (f_in),
      .a_o        (a),
      .b_o        (b),
      .c_o        (c),
      .d_o        (d),
      .busy_o     (busy),
      .done_o     (done),
      .truth_o    (truth),
      .ones_cnt_o (ones)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) glitch_rnd <= 1'($urandom % 2);

   // SOP block under scan; it may glitch on any cycle except the sampling one.
   always_comb begin
      int rel;
      logic smp;
      rel  = cyc - cur_base;
      smp  = (cur_base >= 0) && (rel >= 1) && (rel <= SCAN) && (rel % P == 0);
      f_in = fn_tbl[{a, b, c, d}];
      if (glitch_en && glitch_rnd && !smp) f_in = ~f_in;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: timing model from the scan's start cycle, results from the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         int   rel;
         logic e_busy, e_done;
         logic [3:0] e_vec;
         exp_t e;
         rel    = cyc - cur_base;
         e_busy = (cur_base >= 0) && (rel >= 1) && (rel <= SCAN);
         e_done = (cur_base >= 0) && (rel == SCAN + 1);
         e_vec  = e_busy ? 4'((rel - 1) / P) : 4'd0;
         chk("busy", {31'd0, busy}, {31'd0, e_busy});
         chk("done", {31'd0, done}, {31'd0, e_done});
         chk("vector", {28'd0, a, b, c, d}, {28'd0, e_vec});
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("truth", {16'd0, truth}, {16'd0, e.truth});
               chk("ones_cnt", {27'd0, ones}, {27'd0, e.ones});
               chk("done_cycle", cyc, e.done_cyc);
               hold_truth = e.truth;
               hold_ones  = e.ones;
            end
         end else if (!e_busy && !e_done) begin
            chk("truth_hold", {16'd0, truth}, {16'd0, hold_truth});
            chk("ones_hold", {27'd0, ones}, {27'd0, hold_ones});
         end
      end
   end

   task automatic begin_scan();
      exp_t e;
      cur_base   = cyc;
      e.truth    = fn_tbl;
      e.ones     = 5'($countones(fn_tbl));
      e.done_cyc = cyc + SCAN + 1;
      sb.push_back(e);
   endtask

   task automatic wait_rel(input int r);
      repeat (cur_base + r - cyc) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_scan(input logic [15:0] tbl, input logic g);
      @(posedge clk);
      #1;
      fn_tbl    = tbl;
      glitch_en = g;
      start     = 1'b1;
      begin_scan();
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_rel(SCAN + 2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < %0d", cyc, 20000);
      $fatal(1);
   end

   initial begin
      logic [15:0] tbl;
      int          mins[4] = '{0, 5, 6, 12};
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);

      do_scan(16'h0000, 1'b0);
      do_scan(16'hFFFF, 1'b0);
      tbl = 16'd0;
      foreach (mins[i]) tbl[mins[i]] = 1'b1;
      do_scan(tbl, 1'b1);
      for (int i = 0; i < 16; i++) tbl[i] = (i / 8 == 1) && ((i / 4) % 2 == 1);
      do_scan(tbl, 1'b0);
      for (int i = 0; i < 4; i++) do_scan(16'($urandom), 1'b1);

      // START pulse during a running scan must be ignored.
      @(posedge clk);
      #1;
      fn_tbl    = 16'($urandom);
      glitch_en = 1'b1;
      start     = 1'b1;
      begin_scan();
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_rel(20);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_rel(SCAN + 2);

      // START held high: each new scan is sampled in the IDLE cycle after FINISH.
      @(posedge clk);
      #1;
      fn_tbl = 16'($urandom);
      start  = 1'b1;
      begin_scan();
      for (int k = 0; k < 2; k++) begin
         wait_rel(SCAN + 2);
         fn_tbl = 16'($urandom);
         begin_scan();
      end
      wait_rel(1);
      start = 1'b0;
      wait_rel(SCAN + 2);

      // Mid-scan reset abandons the scan and clears results.
      @(posedge clk);
      #1;
      fn_tbl = 16'($urandom);
      start  = 1'b1;
      begin_scan();
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_rel(30);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      cur_base   = -1;
      hold_truth = 16'd0;
      hold_ones  = 5'd0;
      sb.delete();
      repeat (3) @(posedge clk);
      do_scan(16'($urandom), 1'b1);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
